// File: rtl/trace_pkg.sv
// Shared constants, record layout and FSM encoding for the retirement trace transmitter.
package trace_pkg;

  localparam int unsigned REC_BYTES   = 22;
  localparam int unsigned REC_BITS    = REC_BYTES * 8;
  localparam logic [3:0]  SYNC_NIBBLE = 4'hA;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned RD_W    = 5;
  localparam int unsigned DATA_W  = 64;

  // Index of the last byte of a serialised record.
  localparam logic [4:0] LAST_IDX = 5'd21;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

  // One stored record; the lost flag is captured at push time.
  typedef struct packed {
    logic               lost;
    logic               rd_we;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [RD_W-1:0]    rd;
    logic [DATA_W-1:0]  rd_data;
  } trace_rec_t;

  localparam int unsigned REC_W = $bits(trace_rec_t);

  // Lay a record out as its 22-byte wire image, byte 0 (header) in the low bits.
  function automatic logic [REC_BITS-1:0] pack_record(input trace_rec_t r);
    logic [7:0] header;
    header = {SYNC_NIBBLE, r.lost, 2'b00, r.rd_we};
    return {r.rd_data, 3'b000, r.rd, r.instr, r.pc, header};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Small synchronous FIFO holding complete trace records.
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign do_push_s = push_i && (!full_o || pop_i);
  assign do_pop_s  = pop_i && !empty_o;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Record storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/trace_tx.sv
// Captures retired instructions into a record FIFO and streams each record as 22 bytes.
module trace_tx
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trace_en,
  input  logic        retire_valid,
  input  logic [63:0] retire_pc,
  input  logic [31:0] retire_instr,
  input  logic        retire_rd_we,
  input  logic [4:0]  retire_rd,
  input  logic [63:0] retire_rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        overflow,
  output logic [15:0] drop_count
);

  tx_state_e             state_q, state_d;
  logic [4:0]            idx_q,   idx_d;
  logic [REC_BITS-1:0]   shreg_q, shreg_d;
  logic                  overflow_q;
  logic [15:0]           drop_count_q;
  logic                  pending_drop_q;

  logic                  pop_s;
  logic                  push_s;
  logic                  drop_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [$clog2(DEPTH):0] fifo_count_unused_s;
  trace_rec_t            push_rec_s;
  trace_rec_t            head_rec_s;
  logic [REC_W-1:0]      head_bits_s;

  // Space is judged after any pop on the same edge.
  assign push_s = trace_en && retire_valid && (!fifo_full_s || pop_s);
  assign drop_s = trace_en && retire_valid && fifo_full_s && !pop_s;

  // Assemble the record to be stored, tagging it with any earlier loss.
  always_comb begin
    push_rec_s         = '0;
    push_rec_s.lost    = pending_drop_q;
    push_rec_s.rd_we   = retire_rd_we;
    push_rec_s.pc      = retire_pc;
    push_rec_s.instr   = retire_instr;
    push_rec_s.rd      = retire_rd;
    push_rec_s.rd_data = retire_rd_data;
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_s),
    .push_data_i (push_rec_s),
    .pop_i       (pop_s),
    .pop_data_o  (head_bits_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count_unused_s)
  );

  assign head_rec_s = head_bits_s;

  // The current byte always sits in the low bits of the shift register.
  assign tx_data    = shreg_q[7:0];
  assign tx_valid   = (state_q == ST_SEND);
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

  // Sender FSM: load a record from the FIFO, shift out one byte per handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shreg_d = pack_record(head_rec_s);
          idx_d   = 5'd0;
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            if (!fifo_empty_s) begin
              // Chain straight into the next record without a bubble.
              pop_s   = 1'b1;
              shreg_d = pack_record(head_rec_s);
              idx_d   = 5'd0;
              state_d = ST_SEND;
            end else begin
              idx_d   = 5'd0;
              state_d = ST_IDLE;
            end
          end else begin
            idx_d   = idx_q + 5'd1;
            shreg_d = {8'h00, shreg_q[REC_BITS-1:8]};
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 5'd0;
      end
    endcase
  end

  // Sender state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 5'd0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  // Loss bookkeeping: sticky flag, saturating counter and flag for the next record.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q     <= 1'b0;
      drop_count_q   <= 16'h0000;
      pending_drop_q <= 1'b0;
    end else if (drop_s) begin
      overflow_q     <= 1'b1;
      pending_drop_q <= 1'b1;
      if (drop_count_q != 16'hFFFF) begin
        drop_count_q <= drop_count_q + 16'h0001;
      end
    end else if (push_s) begin
      pending_drop_q <= 1'b0;
    end
  end

endmodule
